// File: rtl/riscv_defs_pkg.sv
// rtl/riscv_defs_pkg.sv - shared ALU op encodings and widths
package riscv_defs_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_NONE             = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SHIFTL           = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_SHIFTR           = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SHIFTR_ARITH     = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_ADD              = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_SUB              = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_AND              = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_OR               = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_XOR              = 4'b1001;
    localparam logic [ALU_OP_W-1:0] ALU_LESS_THAN        = 4'b1010;
    localparam logic [ALU_OP_W-1:0] ALU_LESS_THAN_SIGNED = 4'b1011;

endpackage

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - combinational 32-bit integer ALU; unknown ops pass operand A
module riscv_alu
    import riscv_defs_pkg::*;
(
    input  logic [ALU_OP_W-1:0] alu_op_i,
    input  logic [31:0]         alu_a_i,
    input  logic [31:0]         alu_b_i,
    output logic [31:0]         alu_p_o
);

    always_comb begin
        alu_p_o = alu_a_i;
        unique case (alu_op_i)
            ALU_SHIFTL:           alu_p_o = alu_a_i << alu_b_i[4:0];
            ALU_SHIFTR:           alu_p_o = alu_a_i >> alu_b_i[4:0];
            ALU_SHIFTR_ARITH:     alu_p_o = $unsigned($signed(alu_a_i) >>> alu_b_i[4:0]);
            ALU_ADD:              alu_p_o = alu_a_i + alu_b_i;
            ALU_SUB:              alu_p_o = alu_a_i - alu_b_i;
            ALU_AND:              alu_p_o = alu_a_i & alu_b_i;
            ALU_OR:               alu_p_o = alu_a_i | alu_b_i;
            ALU_XOR:              alu_p_o = alu_a_i ^ alu_b_i;
            ALU_LESS_THAN:        alu_p_o = {31'd0, alu_a_i < alu_b_i};
            ALU_LESS_THAN_SIGNED: alu_p_o = {31'd0, $signed(alu_a_i) < $signed(alu_b_i)};
            default:              alu_p_o = alu_a_i;
        endcase
    end

endmodule

// File: rtl/riscv_alu_arb.sv
// rtl/riscv_alu_arb.sv - shares one riscv_alu among NUM_REQ requesters; RISCV_ALU_ARB_RR_EN selects round-robin
module riscv_alu_arb
    import riscv_defs_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [ALU_OP_W*NUM_REQ-1:0]  req_op_i,
    input  logic [32*NUM_REQ-1:0]        req_a_i,
    input  logic [32*NUM_REQ-1:0]        req_b_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic                         resp_valid_o,
    output logic [ID_W-1:0]              resp_id_o,
    output logic [31:0]                  resp_result_o,
    input  logic                         resp_ready_i
);

    logic                can_accept;
    logic                grant_valid;
    logic [ID_W-1:0]     grant_idx;
    logic                transfer;
    logic [ALU_OP_W-1:0] sel_op;
    logic [31:0]         sel_a;
    logic [31:0]         sel_b;
    logic [31:0]         alu_result;

`ifdef RISCV_ALU_ARB_RR_EN
    logic [ID_W-1:0]     rr_ptr;
    int                  best;
    int                  dist;

    // Pick the valid requester at the smallest circular distance from rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        best        = NUM_REQ;
        dist        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            dist = (k >= int'(rr_ptr)) ? (k - int'(rr_ptr)) : (k + NUM_REQ - int'(rr_ptr));
            if (req_valid_i[k] && (dist < best)) begin
                best        = dist;
                grant_valid = 1'b1;
                grant_idx   = ID_W'(k);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    // Fixed priority: scanning downward leaves the lowest valid index.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(k);
            end
        end
    end
`endif

    assign can_accept  = !resp_valid_o || resp_ready_i;
    assign transfer    = rst_ni && can_accept && grant_valid;
    assign req_ready_o = transfer ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == ID_W'(k)) begin
                sel_op = req_op_i[ALU_OP_W*k +: ALU_OP_W];
                sel_a  = req_a_i[32*k +: 32];
                sel_b  = req_b_i[32*k +: 32];
            end
        end
    end

    riscv_alu u_alu (
        .alu_op_i (sel_op),
        .alu_a_i  (sel_a),
        .alu_b_i  (sel_b),
        .alu_p_o  (alu_result)
    );

    // Id and result hold their last values after a drain; only valid drops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_o  <= 1'b0;
            resp_id_o     <= '0;
            resp_result_o <= '0;
        end else if (transfer) begin
            resp_valid_o  <= 1'b1;
            resp_id_o     <= grant_idx;
            resp_result_o <= alu_result;
        end else if (resp_ready_i) begin
            resp_valid_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_alu_arb.sv
// tb/tb_riscv_alu_arb.sv - scoreboard bench for riscv_alu_arb
module tb_riscv_alu_arb;
    import riscv_defs_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 2;

    logic                        clk = 1'b0;
    logic                        rst_ni = 1'b0;
    logic [NUM_REQ-1:0]          req_valid = '0;
    logic [ALU_OP_W*NUM_REQ-1:0] req_op = '0;
    logic [32*NUM_REQ-1:0]       req_a = '0;
    logic [32*NUM_REQ-1:0]       req_b = '0;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        resp_valid;
    logic [ID_W-1:0]             resp_id;
    logic [31:0]                 resp_result;
    logic                        resp_ready = 1'b0;

    typedef struct {
        int          id;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    riscv_alu_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid),
        .req_op_i      (req_op),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .req_ready_o   (req_ready),
        .resp_valid_o  (resp_valid),
        .resp_id_o     (resp_id),
        .resp_result_o (resp_result),
        .resp_ready_i  (resp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_op[4*k +: 4] = op;
        req_a[32*k +: 32] = a;
        req_b[32*k +: 32] = b;
        req_valid[k] = 1'b1;
    endtask

    task automatic push(input int id, input logic [31:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Every accepted response is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_ni && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_id", 32'(resp_id), 32'(e.id));
                check("resp_result", resp_result, e.res);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with requests pending that must not be granted.
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        set_req(1, ALU_ADD, 32'd2, 32'd2);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_result", resp_result, 32'd0);
        req_valid = '0;
        next_cycle();
        rst_ni = 1'b1;

        // Single request, one-cycle latency.
        next_cycle();
        resp_ready = 1'b1;
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'd1);
        push(0, 32'd12);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("single_latency_valid", 32'(resp_valid), 32'd1);
        @(negedge clk);
        check("single_drained", 32'(resp_valid), 32'd0);

        // Bring the pointer back to 0 before the contention test.
        next_cycle();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        next_cycle();

        // Both requesters valid continuously.
        set_req(0, ALU_SUB, 32'd10, 32'd3);
        set_req(1, ALU_XOR, 32'hFF, 32'h0F);
        for (int i = 0; i < 4; i++) begin
            int exp_id;
`ifdef RISCV_ALU_ARB_RR_EN
            exp_id = i % 2;
`else
            exp_id = 0;
`endif
            @(negedge clk);
            check("contend_ready", 32'(req_ready), 32'(1 << exp_id));
            push(exp_id, (exp_id == 0) ? 32'd7 : 32'hF0);
            next_cycle();
        end
        req_valid = '0;
        repeat (2) next_cycle();

        // Backpressure holds the response and blocks all grants.
        resp_ready = 1'b0;
        set_req(0, ALU_SHIFTR_ARITH, 32'h8000_0000, 32'd4);
        @(negedge clk);
        check("bp_first_ready", 32'(req_ready), 32'd1);
        push(0, 32'hF800_0000);
        next_cycle();
        req_valid = '0;
        set_req(1, ALU_ADD, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_result", resp_result, 32'hF800_0000);
            check("bp_ready", 32'(req_ready), 32'd0);
            next_cycle();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), 32'd2);
        push(1, 32'd3);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("bp_release_valid", 32'(resp_valid), 32'd1);
        next_cycle();

        // Drain and fill in the same cycle.
        set_req(0, ALU_ADD, 32'd2, 32'd2);
        @(negedge clk);
        check("df_first_ready", 32'(req_ready), 32'd1);
        push(0, 32'd4);
        next_cycle();
        req_valid = '0;
        set_req(1, ALU_LESS_THAN_SIGNED, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        check("df_valid", 32'(resp_valid), 32'd1);
        check("df_ready", 32'(req_ready), 32'd2);
        push(1, 32'd1);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("df_no_bubble", 32'(resp_valid), 32'd1);
        next_cycle();

        // Reset mid-operation discards the pending response.
        resp_ready = 1'b0;
        set_req(0, ALU_ADD, 32'h1230, 32'd4);
        @(negedge clk);
        check("mr_ready", 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("mr_pre_valid", 32'(resp_valid), 32'd1);
        check("mr_pre_result", resp_result, 32'h1234);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mr_valid", 32'(resp_valid), 32'd0);
        check("mr_result", resp_result, 32'd0);
        check("mr_id", 32'(resp_id), 32'd0);
        set_req(0, ALU_OR, 32'hF0, 32'h0F);
        set_req(1, ALU_AND, 32'hF0, 32'h3C);
        #1;
        check("mr_ready_in_reset", 32'(req_ready), 32'd0);
        next_cycle();
        rst_ni = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("mr_first_grant", 32'(req_ready), 32'd1);
        push(0, 32'hFF);
        next_cycle();
        req_valid = '0;
        repeat (2) next_cycle();

        // Idle, then an unknown op passes operand A.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(req_ready), 32'd0);
            check("idle_valid", 32'(resp_valid), 32'd0);
        end
        next_cycle();
        set_req(1, 4'hF, 32'hDEAD, 32'd5);
        @(negedge clk);
        check("unk_ready", 32'(req_ready), 32'd2);
        push(1, 32'hDEAD);
        next_cycle();
        req_valid = '0;
        repeat (3) next_cycle();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
